// File: rtl/alu_core.sv
// alu_core: registered integer ALU for the execute stage.
//
// One-cycle latency, full throughput, no backpressure. Every output comes straight from a flop.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid              operands/opcode valid this cycle
//   op[3:0]               operation select (0 ADD .. 11 MUL)
//   operand_a, operand_b  WIDTH-bit operands
//   result                registered WIDTH-bit result
//   out_valid             one-cycle pulse per accepted input
//   flag_zero, flag_neg   result == 0, result sign bit
//   flag_carry, flag_ovf  ADD/SUB carry (SUB: no-borrow) and signed overflow; 0 otherwise
//   illegal_op            unsupported opcode, registered alongside out_valid
//
// Configuration macro: ALU_MUL_EN enables opcode 11 (low WIDTH bits of unsigned a*b).
// Without it no multiplier exists and opcode 11 is reported as illegal.

module alu_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             illegal_op
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpSll   = 4'd5;
  localparam logic [3:0] OpSrl   = 4'd6;
  localparam logic [3:0] OpSra   = 4'd7;
  localparam logic [3:0] OpSlt   = 4'd8;
  localparam logic [3:0] OpSltu  = 4'd9;
  localparam logic [3:0] OpPassb = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OpMul   = 4'd11;
`endif

  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  // Low until the first clock after reset release, so the input on that edge is never taken.
  logic             armed_q;
  logic             accept;

  logic [ShW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             a_msb, b_msb;

  assign shamt    = operand_b[ShW-1:0];
  assign sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff_ext = {1'b0, operand_a} - {1'b0, operand_b};
  assign a_msb    = operand_a[WIDTH-1];
  assign b_msb    = operand_b[WIDTH-1];
  assign accept   = in_valid & armed_q;

  always_comb begin
    result_d  = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (op)
      OpAdd: begin
        result_d = sum_ext[WIDTH-1:0];
        carry_d  = sum_ext[WIDTH];
        ovf_d    = (a_msb == b_msb) && (sum_ext[WIDTH-1] != a_msb);
      end
      OpSub: begin
        result_d = diff_ext[WIDTH-1:0];
        // Top bit of the extended difference is the borrow.
        carry_d  = ~diff_ext[WIDTH];
        ovf_d    = (a_msb != b_msb) && (diff_ext[WIDTH-1] != a_msb);
      end
      OpAnd:   result_d = operand_a & operand_b;
      OpOr:    result_d = operand_a | operand_b;
      OpXor:   result_d = operand_a ^ operand_b;
      OpSll:   result_d = operand_a << shamt;
      OpSrl:   result_d = operand_a >> shamt;
      OpSra:   result_d = $signed(operand_a) >>> shamt;
      OpSlt:   result_d = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OpSltu:  result_d = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      OpPassb: result_d = operand_b;
`ifdef ALU_MUL_EN
      OpMul:   result_d = operand_a * operand_b;
`endif
      default: illegal_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      armed_q     <= 1'b1;
      out_valid_q <= accept;
      if (accept) begin
        result_q  <= result_d;
        zero_q    <= zero_d;
        neg_q     <= neg_d;
        carry_q   <= carry_d;
        ovf_q     <= ovf_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign result     = result_q;
  assign out_valid  = out_valid_q;
  assign flag_zero  = zero_q;
  assign flag_neg   = neg_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares whenever out_valid is high.

module tb_alu_core;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [3:0]       op = 4'd0;
  logic [WIDTH-1:0] operand_a = '0;
  logic [WIDTH-1:0] operand_b = '0;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             flag_zero, flag_neg, flag_carry, flag_ovf, illegal_op;

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .out_valid  (out_valid),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Packed view: {illegal, ovf, carry, neg, zero, result}
  typedef logic [WIDTH+4:0] exp_t;
  typedef struct {
    string name;
    exp_t  val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks = 0;
  int       n_pass = 0;
  exp_t     last_e = '0;
  exp_t     dut_pk;

  assign dut_pk = {illegal_op, flag_ovf, flag_carry, flag_neg, flag_zero, result};

  function automatic exp_t pk(logic [WIDTH-1:0] r, logic z, logic n, logic c, logic v, logic ill);
    return {ill, v, c, n, z, r};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue(string name, logic [3:0] o, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                       exp_t e);
    sb_item_t it;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    it.name   = name;
    it.val    = e;
    sb_q.push_back(it);
    last_e    = e;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out_valid: got result %h with no expected entry", result);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check(it.name, 64'(dut_pk), 64'(it.val));
      end
    end
  end

  initial begin
    exp_t mul_e;
`ifdef ALU_MUL_EN
    mul_e = pk(32'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    mul_e = pk(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Reset
    #1 rst_n = 1'b0;
    #3;
    check("reset_state", 64'({out_valid, dut_pk}), 64'd0);
    #20 rst_n = 1'b1;
    idle();
    idle();

    // Back-to-back directed vectors
    issue("add_1_2",   4'd0,  32'd1,        32'd2,        pk(32'd3, 0, 0, 0, 0, 0));
    issue("add_ovf",   4'd0,  32'h7FFFFFFF, 32'd1,        pk(32'h80000000, 0, 1, 0, 1, 0));
    issue("sub_eq",    4'd1,  32'd5,        32'd5,        pk(32'd0, 1, 0, 1, 0, 0));
    issue("sra",       4'd7,  32'h80000000, 32'h24,       pk(32'hF8000000, 0, 1, 0, 0, 0));
    issue("srl",       4'd6,  32'h80000000, 32'h24,       pk(32'h08000000, 0, 0, 0, 0, 0));
    issue("slt",       4'd8,  32'hFFFFFFFF, 32'd1,        pk(32'd1, 0, 0, 0, 0, 0));
    issue("sltu",      4'd9,  32'hFFFFFFFF, 32'd1,        pk(32'd0, 1, 0, 0, 0, 0));
    issue("illegal13", 4'd13, 32'd9,        32'd9,        pk(32'd0, 1, 0, 0, 0, 1));
    issue("op11_mul",  4'd11, 32'd6,        32'd7,        mul_e);
    issue("and",       4'd2,  32'hF0F0F0F0, 32'hFF00FF00, pk(32'hF000F000, 0, 1, 0, 0, 0));
    issue("or",        4'd3,  32'hF0F0F0F0, 32'hFF00FF00, pk(32'hFFF0FFF0, 0, 1, 0, 0, 0));
    issue("xor",       4'd4,  32'hF0F0F0F0, 32'hFF00FF00, pk(32'h0FF00FF0, 0, 0, 0, 0, 0));
    issue("sll",       4'd5,  32'd1,        32'h21,       pk(32'd2, 0, 0, 0, 0, 0));
    issue("passb",     4'd10, 32'd0,        32'h12345678, pk(32'h12345678, 0, 0, 0, 0, 0));
    issue("add_carry", 4'd0,  32'hFFFFFFFF, 32'd1,        pk(32'd0, 1, 0, 1, 0, 0));
    issue("sub_borrow",4'd1,  32'd0,        32'd1,        pk(32'hFFFFFFFF, 0, 1, 0, 0, 0));
    issue("sub_ovf",   4'd1,  32'h80000000, 32'd1,        pk(32'h7FFFFFFF, 0, 0, 1, 1, 0));
    idle();

    // Hold with in_valid low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_value", 64'(dut_pk), 64'(last_e));
    check("hold_no_valid", 64'(out_valid), 64'd0);
    check("stream_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset mid-stream
    issue("pre_rst_a", 4'd0, 32'd100, 32'd1, pk(32'd101, 0, 0, 0, 0, 0));
    issue("pre_rst_b", 4'd0, 32'd200, 32'd1, pk(32'd201, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_reset", 64'({out_valid, dut_pk}), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post_release_0", 64'({out_valid, dut_pk}), 64'd0);
    @(negedge clk);
    check("post_release_1", 64'({out_valid, dut_pk}), 64'd0);

    issue("add_after_rst", 4'd0, 32'd10, 32'd20, pk(32'd30, 0, 0, 0, 0, 0));
    idle();
    repeat (2) @(negedge clk);
    check("final_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Registered integer ALU for the datapath execute stage: takes two WIDTH-bit operands and a 4-bit opcode, and produces a WIDTH-bit result plus status flags one clock later. The block is the synthesizable `alu_core` module. Its ports `operand_a`, `operand_b` and `result` match the execute-stage wiring, and opcode 0 (ADD) is the default operation.

## Interface
- WIDTH, 32, operand/result bit width (legal: 8..64, power of two).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/opcode valid this cycle.
- op  input  4  operation select (see Operation).
- operand_a  input  WIDTH  first operand.
- operand_b  input  WIDTH  second operand.
- result  output  WIDTH  registered result.
- out_valid  output  1  result/flags valid; high exactly one cycle per accepted input.
- flag_zero  output  1  result == 0.
- flag_neg  output  1  result[WIDTH-1].
- flag_carry  output  1  ADD carry-out / SUB no-borrow (a >= b unsigned); 0 for other ops.
- flag_ovf  output  1  signed overflow for ADD/SUB; 0 for other ops.
- illegal_op  output  1  opcode unsupported; registered alongside out_valid.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SLL a<<b[log2(WIDTH)-1:0]; 6 SRL logical; 7 SRA arithmetic; 8 SLT signed (result 1/0); 9 SLTU unsigned; 10 PASSB (result = b); 11 MUL (low WIDTH bits of a*b, only with ALU_MUL_EN).
- Shift amount uses only the low log2(WIDTH) bits of operand_b; upper bits ignored.
- ADD/SUB wrap modulo 2^WIDTH. Overflow: ADD when a,b same sign and result sign differs; SUB when a,b differ in sign and result sign differs from a.
- Unsupported opcodes (12-15, and 11 without ALU_MUL_EN): result = 0, all arithmetic flags 0 except flag_zero = 1, illegal_op = 1.
- When in_valid = 0: result and flags hold their previous values; out_valid = 0 next cycle.
- No backpressure; every valid input is accepted.

## Timing
- Latency 1 cycle: inputs sampled on rising clk with in_valid = 1 appear on result/flags after that edge, with out_valid = 1 for one cycle.
- Back-to-back inputs: one result per cycle, full throughput.
- Reset (rst_n low, asynchronous, any time including mid-stream): result = 0, out_valid = 0, flag_zero = 0, flag_neg = 0, flag_carry = 0, flag_ovf = 0, illegal_op = 0. An input sampled on the same edge as reset release is ignored.
- All outputs are driven directly from flops; no combinational input-to-output path.

## Configuration
- ALU_MUL_EN defined: opcode 11 computes the low WIDTH bits of the unsigned product, still with 1-cycle latency; flag_carry and flag_ovf are 0.
- ALU_MUL_EN undefined: no multiplier is synthesized, and opcode 11 is handled as illegal.

## Test plan
- Reset, then ADD a=1, b=2, in_valid=1 -> next cycle result=3, out_valid=1, all flags 0, illegal_op=0.
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, flag_ovf=1, flag_neg=1, flag_carry=0; SUB a=5, b=5 -> result=0, flag_zero=1, flag_carry=1.
- SRA a=0x80000000, b=0x24 (shift 4) -> result=0xF8000000; SRL of the same -> 0x08000000; SLT a=-1, b=1 -> 1; SLTU same -> 0.
- Opcode 13 -> result=0, flag_zero=1, illegal_op=1; opcode 11 with a=6, b=7 -> 42 with ALU_MUL_EN, illegal otherwise.
- Four back-to-back valid inputs, then in_valid=0 -> four consecutive out_valid pulses with matching results; result held afterwards with out_valid=0.
- Assert rst_n low asynchronously between clock edges during a stream -> all outputs 0 immediately; no stale out_valid after release.
